// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU, register file and memory port.
// Datapath selects follow the state plus the class latched in DECODE; data-memory states wait on MemReady.
module legv8_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [10:0]      Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       SignOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       StateOut
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    LOAD_WB  = 4'd6,
    MEM_WR   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_R    = 3'd1,
    CL_I    = 3'd2,
    CL_LD   = 3'd3,
    CL_ST   = 3'd4,
    CL_CBZ  = 3'd5,
    CL_B    = 3'd6
  } cls_t;

  state_t state;
  cls_t   cls;
  cls_t   dec_cls;

  logic ir_wr, pc_wr, reg_wr, mem_rd, mem_wr;
  logic retire;

  function automatic cls_t classify(input logic [10:0] op);
    cls_t c;
    c = CL_NONE;
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550)
      c = CL_R;
    else if (op[10:1] == 10'h244)
      c = CL_I;
    else if (op == 11'h7C2)
      c = CL_LD;
    else if (op == 11'h7C0)
      c = CL_ST;
    else if (op[10:3] == 8'hB4)
      c = CL_CBZ;
    else if (op[10:5] == 6'h05)
      c = CL_B;
    return c;
  endfunction

  always_comb dec_cls = classify(Opcode);

  // An illegal opcode advances the PC from DECODE but does not count as retired.
  assign retire = pc_wr && (state != DECODE);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= FETCH;
      cls        <= CL_NONE;
      Illegal    <= 1'b0;
      InstrCount <= '0;
    end else begin
      if (retire)
        InstrCount <= InstrCount + CNT_W'(1);
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          cls <= dec_cls;
          case (dec_cls)
            CL_R:          state <= EXEC_R;
            CL_I:          state <= EXEC_I;
            CL_LD, CL_ST:  state <= MEM_ADDR;
            CL_CBZ, CL_B:  state <= BRANCH;
            default: begin
              Illegal <= 1'b1;
              state   <= FETCH;
            end
          endcase
        end
        EXEC_R, EXEC_I: state <= ALU_WB;
        ALU_WB:         state <= FETCH;
        MEM_ADDR:       state <= (cls == CL_ST) ? MEM_WR : MEM_RD;
        MEM_RD:         if (MemReady) state <= LOAD_WB;
        LOAD_WB:        state <= FETCH;
        MEM_WR:         if (MemReady) state <= FETCH;
        BRANCH:         state <= FETCH;
        default:        state <= FETCH;
      endcase
    end
  end

  always_comb begin
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    reg_wr   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    PCSrc    = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    SignOp   = 2'b00;
    MemtoReg = 1'b0;
    case (state)
      FETCH: ir_wr = 1'b1;
      DECODE: begin
        if (dec_cls == CL_NONE)
          pc_wr = 1'b1;
      end
      EXEC_R: ALUOp = 2'b10;
      EXEC_I: ALUSrc = 1'b1;
      ALU_WB: begin
        if (cls == CL_R) ALUOp = 2'b10;
        else             ALUSrc = 1'b1;
        reg_wr = 1'b1;
        pc_wr  = 1'b1;
      end
      MEM_ADDR: begin
        ALUSrc  = 1'b1;
        SignOp  = 2'b01;
        Reg2Loc = (cls == CL_ST);
      end
      MEM_RD: begin
        ALUSrc = 1'b1;
        SignOp = 2'b01;
        mem_rd = 1'b1;
      end
      LOAD_WB: begin
        MemtoReg = 1'b1;
        reg_wr   = 1'b1;
        pc_wr    = 1'b1;
      end
      MEM_WR: begin
        ALUSrc  = 1'b1;
        SignOp  = 2'b01;
        Reg2Loc = 1'b1;
        mem_wr  = 1'b1;
        pc_wr   = MemReady;
      end
      BRANCH: begin
        pc_wr = 1'b1;
        if (cls == CL_CBZ) begin
          SignOp  = 2'b11;
          Reg2Loc = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = Zero;
        end else begin
          SignOp = 2'b10;
          PCSrc  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Enables are gated by Reset directly so an aborted memory request drops immediately.
  assign IRWrite  = ir_wr  & ~Reset;
  assign PCWrite  = pc_wr  & ~Reset;
  assign RegWrite = reg_wr & ~Reset;
  assign MemRead  = mem_rd & ~Reset;
  assign MemWrite = mem_wr & ~Reset;
  assign StateOut = state;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl: walks each instruction class cycle by cycle with hand-computed expectations.
module tb_legv8_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [10:0] Opcode;
  logic        Zero;
  logic        MemReady;
  logic        IRWrite, PCWrite, PCSrc, Reg2Loc, RegWrite, ALUSrc;
  logic [1:0]  ALUOp, SignOp;
  logic        MemRead, MemWrite, MemtoReg, Illegal;
  logic [31:0] InstrCount;
  logic [3:0]  StateOut;

  int checks = 0;
  int errors = 0;

  legv8_multicycle_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .SignOp(SignOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .Illegal(Illegal),
    .InstrCount(InstrCount), .StateOut(StateOut)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; Opcode = 11'h000; Zero = 1'b0; MemReady = 1'b1;
    #3;
    chk("rst_state",   32'(StateOut), 0);
    chk("rst_count",   InstrCount, 0);
    chk("rst_illegal", 32'(Illegal), 0);
    chk("rst_irwrite", 32'(IRWrite), 0);
    chk("rst_pcwrite", 32'(PCWrite), 0);
    tick();
    Reset = 1'b0;
    #1;
    chk("fetch_state", 32'(StateOut), 0);
    chk("fetch_irw",   32'(IRWrite), 1);

    // ADD
    Opcode = 11'h458;
    tick();
    chk("add_dec",     32'(StateOut), 1);
    chk("add_dec_pcw", 32'(PCWrite), 0);
    tick();
    chk("add_exec",    32'(StateOut), 2);
    chk("add_exec_op", 32'(ALUOp), 2);
    chk("add_exec_rw", 32'(RegWrite), 0);
    tick();
    chk("add_wb",      32'(StateOut), 8);
    chk("add_wb_rw",   32'(RegWrite), 1);
    chk("add_wb_pcw",  32'(PCWrite), 1);
    chk("add_wb_src",  32'(PCSrc), 0);
    tick();
    chk("add_fetch",   32'(StateOut), 0);
    chk("add_count",   InstrCount, 1);

    // LDUR with MemReady low for three MEM_RD cycles
    Opcode = 11'h7C2; MemReady = 1'b0;
    tick();
    chk("ld_dec",      32'(StateOut), 1);
    tick();
    chk("ld_addr",     32'(StateOut), 4);
    chk("ld_addr_so",  32'(SignOp), 1);
    chk("ld_addr_src", 32'(ALUSrc), 1);
    chk("ld_addr_r2l", 32'(Reg2Loc), 0);
    chk("ld_addr_mr",  32'(MemRead), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        MemReady = 1'b1;
        #1;
      end
      chk("ld_rd_state", 32'(StateOut), 5);
      chk("ld_rd_mr",    32'(MemRead), 1);
      chk("ld_rd_so",    32'(SignOp), 1);
      chk("ld_rd_pcw",   32'(PCWrite), 0);
    end
    tick();
    chk("ld_wb",       32'(StateOut), 6);
    chk("ld_wb_m2r",   32'(MemtoReg), 1);
    chk("ld_wb_rw",    32'(RegWrite), 1);
    chk("ld_wb_pcw",   32'(PCWrite), 1);
    chk("ld_wb_mr",    32'(MemRead), 0);
    tick();
    chk("ld_fetch",    32'(StateOut), 0);
    chk("ld_count",    InstrCount, 2);

    // CBZ taken
    Opcode = 11'h5A0; Zero = 1'b1;
    tick();
    tick();
    chk("cbz1_state",  32'(StateOut), 9);
    chk("cbz1_so",     32'(SignOp), 3);
    chk("cbz1_r2l",    32'(Reg2Loc), 1);
    chk("cbz1_op",     32'(ALUOp), 1);
    chk("cbz1_src",    32'(ALUSrc), 0);
    chk("cbz1_pcsrc",  32'(PCSrc), 1);
    chk("cbz1_pcw",    32'(PCWrite), 1);
    tick();
    chk("cbz1_fetch",  32'(StateOut), 0);
    chk("cbz1_count",  InstrCount, 3);

    // CBZ not taken
    Zero = 1'b0;
    tick();
    tick();
    chk("cbz0_state",  32'(StateOut), 9);
    chk("cbz0_pcsrc",  32'(PCSrc), 0);
    chk("cbz0_pcw",    32'(PCWrite), 1);
    tick();
    chk("cbz0_count",  InstrCount, 4);

    // B
    Opcode = 11'h0A0;
    tick();
    tick();
    chk("b_state",     32'(StateOut), 9);
    chk("b_so",        32'(SignOp), 2);
    chk("b_pcsrc",     32'(PCSrc), 1);
    chk("b_r2l",       32'(Reg2Loc), 0);
    tick();
    chk("b_count",     InstrCount, 5);

    // STUR with one wait cycle
    Opcode = 11'h7C0; MemReady = 1'b0;
    tick();
    tick();
    chk("st_addr",     32'(StateOut), 4);
    chk("st_addr_r2l", 32'(Reg2Loc), 1);
    chk("st_addr_so",  32'(SignOp), 1);
    tick();
    chk("st_wr",       32'(StateOut), 7);
    chk("st_wr_mw",    32'(MemWrite), 1);
    chk("st_wr_r2l",   32'(Reg2Loc), 1);
    chk("st_wr_pcw0",  32'(PCWrite), 0);
    chk("st_wr_rw0",   32'(RegWrite), 0);
    MemReady = 1'b1;
    #1;
    chk("st_wr_pcw1",  32'(PCWrite), 1);
    chk("st_wr_rw1",   32'(RegWrite), 0);
    chk("st_wr_mw1",   32'(MemWrite), 1);
    tick();
    chk("st_fetch",    32'(StateOut), 0);
    chk("st_count",    InstrCount, 6);

    // Illegal opcode
    Opcode = 11'h000;
    tick();
    chk("ill_dec",     32'(StateOut), 1);
    chk("ill_dec_pcw", 32'(PCWrite), 1);
    chk("ill_dec_src", 32'(PCSrc), 0);
    chk("ill_pre",     32'(Illegal), 0);
    tick();
    chk("ill_fetch",   32'(StateOut), 0);
    chk("ill_flag",    32'(Illegal), 1);
    chk("ill_count",   InstrCount, 6);

    // ADDI after illegal
    Opcode = 11'h488;
    tick();
    tick();
    chk("addi_exec",   32'(StateOut), 3);
    chk("addi_src",    32'(ALUSrc), 1);
    chk("addi_op",     32'(ALUOp), 0);
    chk("addi_so",     32'(SignOp), 0);
    tick();
    chk("addi_wb",     32'(StateOut), 8);
    chk("addi_wb_rw",  32'(RegWrite), 1);
    tick();
    chk("addi_count",  InstrCount, 7);
    chk("addi_ill",    32'(Illegal), 1);

    // Reset in the middle of a stalled store
    Opcode = 11'h7C0; MemReady = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_wr_state", 32'(StateOut), 7);
    chk("rst_wr_mw",    32'(MemWrite), 1);
    Reset = 1'b1;
    #1;
    chk("rst_async_mw",    32'(MemWrite), 0);
    chk("rst_async_state", 32'(StateOut), 0);
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_rel_state", 32'(StateOut), 0);
    chk("rst_rel_count", InstrCount, 0);
    chk("rst_rel_ill",   32'(Illegal), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
